// File: rtl/cplx_divider.sv
// Sequential signed complex divider: q = num * conj(den) / |den|^2, one quotient bit per cycle.
// Define CPLX_DIV_ROUND_EN to round half away from zero instead of truncating toward zero.
module cplx_divider #(
    parameter int unsigned NW = 16,
    parameter int unsigned DW = 8,
    parameter int unsigned QW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [NW-1:0] num_real,
    input  logic [NW-1:0] num_imag,
    input  logic [DW-1:0] den_real,
    input  logic [DW-1:0] den_imag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [QW-1:0] q_real,
    output logic [QW-1:0] q_imag,
    output logic          overflow,
    output logic          div_by_zero
);

    localparam int unsigned PW = NW + DW + 1;
    localparam int unsigned MW = 2 * DW;
    localparam int unsigned CW = $clog2(PW);
    localparam logic [PW:0] LimPos = (PW+1)'(2 ** (QW - 1) - 1);
    localparam logic [PW:0] LimNeg = (PW+1)'(2 ** (QW - 1));

    typedef enum logic [2:0] {StIdle, StPrep, StDiv, StFin, StDone} state_e;

    state_e r_state, w_state_next;

    logic signed [NW-1:0] r_num_re, r_num_im;
    logic signed [DW-1:0] r_den_re, r_den_im;
    logic [PW-1:0]        r_qr_re, r_qr_im;
    logic [MW-1:0]        r_rem_re, r_rem_im;
    logic [MW-1:0]        r_mag;
    logic [CW-1:0]        r_cnt;
    logic                 r_neg_re, r_neg_im, r_dz_pend;
    logic                 r_out_valid, r_ovf, r_dz;
    logic [QW-1:0]        r_q_re, r_q_im;

    // One restoring step: returns {quotient bit, new remainder}. The remainder is always below
    // mag, so the modular MW-bit subtraction is exact whenever the bit is set.
    function automatic logic [MW:0] f_step(input logic [MW-1:0] rem, input logic msb,
                                           input logic [MW-1:0] mag);
        logic [MW:0] sh;
        logic        ge;
        sh = {rem, msb};
        ge = (sh >= {1'b0, mag});
        return {ge, ge ? (sh[MW-1:0] - mag) : sh[MW-1:0]};
    endfunction

    // Returns {clipped, value} for a magnitude and sign.
    function automatic logic [QW:0] f_sat(input logic [PW:0] mag, input logic neg);
        if (mag > (neg ? LimNeg : LimPos)) begin
            return {1'b1, neg, {(QW-1){~neg}}};
        end
        return {1'b0, QW'(neg ? -mag : mag)};
    endfunction

    logic signed [PW-1:0] w_nre, w_nim, w_dre, w_dim, w_nr, w_ni;
    logic signed [MW-1:0] w_dre_m, w_dim_m, w_dr_sq, w_di_sq;
    logic [MW-1:0]        w_mag;
    logic [PW-1:0]        w_nr_abs, w_ni_abs;
    logic [MW:0]          w_step_re, w_step_im;
    logic                 w_inc_re, w_inc_im;
    logic [PW:0]          w_qm_re, w_qm_im;
    logic [QW:0]          w_sat_re, w_sat_im;

    assign w_nre    = PW'(r_num_re);
    assign w_nim    = PW'(r_num_im);
    assign w_dre    = PW'(r_den_re);
    assign w_dim    = PW'(r_den_im);
    assign w_nr     = w_nre * w_dre + w_nim * w_dim;
    assign w_ni     = w_nim * w_dre - w_nre * w_dim;
    assign w_dre_m  = MW'(r_den_re);
    assign w_dim_m  = MW'(r_den_im);
    assign w_dr_sq  = w_dre_m * w_dre_m;
    assign w_di_sq  = w_dim_m * w_dim_m;
    assign w_mag    = $unsigned(w_dr_sq) + $unsigned(w_di_sq);
    assign w_nr_abs = w_nr[PW-1] ? $unsigned(-w_nr) : $unsigned(w_nr);
    assign w_ni_abs = w_ni[PW-1] ? $unsigned(-w_ni) : $unsigned(w_ni);

    assign w_step_re = f_step(r_rem_re, r_qr_re[PW-1], r_mag);
    assign w_step_im = f_step(r_rem_im, r_qr_im[PW-1], r_mag);

`ifdef CPLX_DIV_ROUND_EN
    assign w_inc_re = ({r_rem_re, 1'b0} >= {1'b0, r_mag});
    assign w_inc_im = ({r_rem_im, 1'b0} >= {1'b0, r_mag});
`else
    assign w_inc_re = 1'b0;
    assign w_inc_im = 1'b0;
`endif

    assign w_qm_re  = {1'b0, r_qr_re} + {{PW{1'b0}}, w_inc_re};
    assign w_qm_im  = {1'b0, r_qr_im} + {{PW{1'b0}}, w_inc_im};
    assign w_sat_re = f_sat(w_qm_re, r_neg_re);
    assign w_sat_im = f_sat(w_qm_im, r_neg_im);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        case (r_state)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = StPrep;
                end
            end
            StPrep:  w_state_next = (w_mag == '0) ? StFin : StDiv;
            StDiv: begin
                if (r_cnt == CW'(PW - 1)) begin
                    w_state_next = StFin;
                end
            end
            StFin:   w_state_next = StDone;
            StDone: begin
                if (out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_num_re    <= '0;
            r_num_im    <= '0;
            r_den_re    <= '0;
            r_den_im    <= '0;
            r_qr_re     <= '0;
            r_qr_im     <= '0;
            r_rem_re    <= '0;
            r_rem_im    <= '0;
            r_mag       <= '0;
            r_cnt       <= '0;
            r_neg_re    <= 1'b0;
            r_neg_im    <= 1'b0;
            r_dz_pend   <= 1'b0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_dz        <= 1'b0;
            r_q_re      <= '0;
            r_q_im      <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_num_re <= num_real;
                        r_num_im <= num_imag;
                        r_den_re <= den_real;
                        r_den_im <= den_imag;
                    end
                end
                StPrep: begin
                    r_qr_re   <= w_nr_abs;
                    r_qr_im   <= w_ni_abs;
                    r_neg_re  <= w_nr[PW-1];
                    r_neg_im  <= w_ni[PW-1];
                    r_mag     <= w_mag;
                    r_rem_re  <= '0;
                    r_rem_im  <= '0;
                    r_cnt     <= '0;
                    r_dz_pend <= (w_mag == '0);
                end
                StDiv: begin
                    // The dividend shifts out MSB first while quotient bits fill in from the LSB.
                    r_qr_re  <= {r_qr_re[PW-2:0], w_step_re[MW]};
                    r_qr_im  <= {r_qr_im[PW-2:0], w_step_im[MW]};
                    r_rem_re <= w_step_re[MW-1:0];
                    r_rem_im <= w_step_im[MW-1:0];
                    r_cnt    <= r_cnt + 1'b1;
                end
                StFin: begin
                    r_out_valid <= 1'b1;
                    if (r_dz_pend) begin
                        r_q_re <= '0;
                        r_q_im <= '0;
                        r_ovf  <= 1'b0;
                        r_dz   <= 1'b1;
                    end else begin
                        r_q_re <= w_sat_re[QW-1:0];
                        r_q_im <= w_sat_im[QW-1:0];
                        r_ovf  <= w_sat_re[QW] | w_sat_im[QW];
                        r_dz   <= 1'b0;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid   = r_out_valid;
    assign q_real      = r_q_re;
    assign q_imag      = r_q_im;
    assign overflow    = r_ovf;
    assign div_by_zero = r_dz;

endmodule

// File: tb/tb_cplx_divider.sv
// Self-checking bench for cplx_divider: vector table plus random ops through a scoreboard,
// with hand-written backpressure and mid-operation reset sequences.
module tb_cplx_divider;

    localparam int NW = 16;
    localparam int DW = 8;
    localparam int QW = 8;
`ifdef CPLX_DIV_ROUND_EN
    localparam bit Rnd = 1'b1;
`else
    localparam bit Rnd = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [NW-1:0] num_real, num_imag;
    logic [DW-1:0] den_real, den_imag;
    logic          out_valid;
    logic          out_ready;
    logic [QW-1:0] q_real, q_imag;
    logic          overflow;
    logic          div_by_zero;

    cplx_divider #(.NW(NW), .DW(DW), .QW(QW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .num_real    (num_real),
        .num_imag    (num_imag),
        .den_real    (den_real),
        .den_imag    (den_imag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .q_real      (q_real),
        .q_imag      (q_imag),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {int qr; int qi; bit ovf; bit dz;} exp_t;
    typedef struct {int nr; int ni; int dr; int di; exp_t e;} vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: exact integer arithmetic, truncation by SV division, optional rounding.
    function automatic exp_t model(input int nr, input int ni, input int dr, input int di);
        exp_t    r;
        longint  p[2];
        longint  q;
        longint  rm;
        longint  m;
        int      qv[2];
        bit      ov;
        p[0] = longint'(nr) * dr + longint'(ni) * di;
        p[1] = longint'(ni) * dr - longint'(nr) * di;
        m    = longint'(dr) * dr + longint'(di) * di;
        ov   = 1'b0;
        if (m == 0) return '{0, 0, 1'b0, 1'b1};
        for (int k = 0; k < 2; k++) begin
            q  = p[k] / m;
            rm = p[k] % m;
            if (Rnd && (2 * (rm < 0 ? -rm : rm) >= m)) q += (p[k] < 0) ? -1 : 1;
            if (q > 127) begin q = 127; ov = 1'b1; end
            if (q < -128) begin q = -128; ov = 1'b1; end
            qv[k] = int'(q);
        end
        r = '{qv[0], qv[1], ov, 1'b0};
        return r;
    endfunction

    // Scoreboard: compare every handshaken result against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("q_real", int'($signed(q_real)), e.qr);
                chk("q_imag", int'($signed(q_imag)), e.qi);
                chk("overflow", int'(overflow), int'(e.ovf));
                chk("div_by_zero", int'(div_by_zero), int'(e.dz));
            end
        end
    end

    task automatic drive_ops(input int nr, input int ni, input int dr, input int di);
        num_real = NW'(nr);
        num_imag = NW'(ni);
        den_real = DW'(dr);
        den_imag = DW'(di);
    endtask

    // Waits for in_ready, presents the op for exactly the acceptance edge, then scrambles operands.
    task automatic accept(input vec_t v, input bit push);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        drive_ops(v.nr, v.ni, v.dr, v.di);
        in_valid = 1'b1;
        @(posedge clk);
        if (push) sb.push_back(v.e);
        #1;
        in_valid = 1'b0;
        drive_ops(int'($urandom), int'($urandom), int'($urandom), int'($urandom));
    endtask

    task automatic send(input vec_t v);
        int n = 0;
        accept(v, 1'b1);
        while (n < 100) begin
            @(posedge clk);
            n++;
            #1;
            if (out_valid) break;
        end
        chk("latency", n, v.e.dz ? 2 : 27);
    endtask

    vec_t tbl[$];
    vec_t v;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl.push_back('{-2, 14, 2, 2, '{3, 4, 1'b0, 1'b0}});
        tbl.push_back('{7, 0, 2, 0, '{Rnd ? 4 : 3, 0, 1'b0, 1'b0}});
        tbl.push_back('{-7, 0, 2, 0, '{Rnd ? -4 : -3, 0, 1'b0, 1'b0}});
        tbl.push_back('{1000, 0, 1, 0, '{127, 0, 1'b1, 1'b0}});
        tbl.push_back('{-1000, 0, 1, 0, '{-128, 0, 1'b1, 1'b0}});
        tbl.push_back('{5, 5, 0, 0, '{0, 0, 1'b0, 1'b1}});
        tbl.push_back('{-32768, -32768, -128, -128, '{127, 0, 1'b1, 1'b0}});
        tbl.push_back('{100, 50, 3, -4, '{4, 22, 1'b0, 1'b0}});
        tbl.push_back('{-128, 0, 1, 0, '{-128, 0, 1'b0, 1'b0}});
        tbl.push_back('{128, 0, 1, 0, '{127, 0, 1'b1, 1'b0}});
        tbl.push_back('{10, 0, 0, 1, '{0, -10, 1'b0, 1'b0}});
        tbl.push_back('{255, 0, 2, 0, '{127, 0, Rnd, 1'b0}});
        tbl.push_back('{-255, 0, 2, 0, '{Rnd ? -128 : -127, 0, 1'b0, 1'b0}});
        tbl.push_back('{-5, 0, 0, 2, '{0, Rnd ? 3 : 2, 1'b0, 1'b0}});
        tbl.push_back('{32767, -32768, 127, -128, '{127, 1, 1'b1, 1'b0}});

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive_ops(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_q", int'({q_real, q_imag}), 0);
        chk("rst_flags", int'({overflow, div_by_zero}), 0);
        rst = 1'b0;

        foreach (tbl[i]) send(tbl[i]);

        for (int i = 0; i < 12; i++) begin
            v.nr = int'($urandom_range(0, 65535)) - 32768;
            v.ni = int'($urandom_range(0, 65535)) - 32768;
            v.dr = int'($urandom_range(0, 255)) - 128;
            v.di = int'($urandom_range(0, 255)) - 128;
            if (i < 6) begin
                v.nr = v.nr / 256;
                v.ni = v.ni / 256;
            end
            v.e = model(v.nr, v.ni, v.dr, v.di);
            send(v);
        end

        // Backpressure: hold the result for 10 cycles while a second request is offered.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(tbl[0]);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i < 6);
            drive_ops(1000, 0, 1, 0);
            @(posedge clk);
            #1;
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_q_real", int'($signed(q_real)), 3);
            chk("bp_q_imag", int'($signed(q_imag)), 4);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_out_valid_drop", int'(out_valid), 0);
        chk("bp_in_ready_back", int'(in_ready), 1);
        chk("bp_one_handshake", sb.size(), 0);
        repeat (4) @(posedge clk);
        #1;
        chk("bp_no_second_op", int'(out_valid), 0);

        // Reset at edge T+10 of a division discards it without output.
        v = '{1000, 0, 1, 0, '{127, 0, 1'b1, 1'b0}};
        accept(v, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_in_ready", int'(in_ready), 1);
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_q_real", int'(q_real), 0);
        chk("mid_rst_q_imag", int'(q_imag), 0);
        repeat (30) @(posedge clk);
        #1;
        chk("mid_rst_no_output", int'(out_valid), 0);
        send(tbl[7]);

        begin
            int n = 0;
            while (sb.size() != 0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("sb_drained", sb.size(), 0);
        end
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cplx_divider.md
Name: cplx_divider

Overview:
- Sequential signed complex divider; the inverse of the team's combinational complex multiplier.
- Given a product num = a·b and a known factor den = b, it recovers quotient q ≈ num/den.
- Used to check multiplier results in hardware and to undo channel gains.
- Computes q = num·conj(den) / |den|², using two parallel restoring dividers (real and imag), one bit per cycle, with valid/ready handshakes on both sides.

Parameters:
- NW, 16, numerator component width (signed).
- DW, 8, denominator component width (signed).
- QW, 8, quotient component width (signed, saturating).

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- num_real  input  NW  signed numerator real part.
- num_imag  input  NW  signed numerator imaginary part.
- den_real  input  DW  signed denominator real part.
- den_imag  input  DW  signed denominator imaginary part.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- q_real  output  QW  signed quotient real part.
- q_imag  output  QW  signed quotient imaginary part.
- overflow  output  1  either component saturated.
- div_by_zero  output  1  den was 0+0i.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE, in_ready=1, out_valid=0, q_real=q_imag=0, overflow=0, div_by_zero=0.
  - Takes effect from any state, including mid-division; any in-flight operation is discarded with no output.
- States and transitions:
  - IDLE: in_valid&in_ready at edge T latches all four operands and moves to PREP; in_ready drops after T.
  - PREP (edge T+1):
    - nr = num_real·den_real + num_imag·den_imag
    - ni = num_imag·den_real − num_real·den_imag
    - nr/ni are signed, NW+DW+1 bits wide.
    - mag = den_real² + den_imag², unsigned, 2·DW bits (max 32768 fits).
    - Latch the signs and magnitudes |nr|, |ni| (NW+DW+1 = 25 bits unsigned).
    - mag==0: go to FIN with div_by_zero pending. Otherwise go to DIV with the iteration counter = 0.
  - DIV (edges T+2..T+NW+DW+2): NW+DW+1 = 25 restoring iterations, MSB first, both components in lockstep. After the last iteration go to FIN.
  - FIN (edge T+NW+DW+3 = T+27; T+2 for zero den):
    - Apply sign: negative iff the sign of nr (resp. ni) is negative, since mag is always positive.
    - Truncate toward zero.
    - Saturate to [−2^(QW−1), 2^(QW−1)−1]; set overflow if either component clipped.
    - Zero den: q=0+0i, div_by_zero=1, overflow=0.
    - Register the outputs, set out_valid=1, go to DONE.
  - DONE: hold all outputs stable while out_valid&!out_ready.
    - On out_valid&out_ready: out_valid=0, go to IDLE, in_ready=1 the next cycle.
    - q/flags keep their last values after the handshake.
- Throughput: one operation per NW+DW+5 cycles minimum; no overlap of operations.
- in_valid while busy is ignored; the source must hold it until in_ready.
- Operands must not be sampled outside the IDLE acceptance edge; changes during a division have no effect.
- Worst case |num|=2^15 and |den|=2^7 must not overflow the internal widths.

Optional Feature:
- Macro: CPLX_DIV_ROUND_EN.
- Defined: round half away from zero.
  - FIN compares 2·remainder ≥ mag per component and increments the magnitude before sign and saturation.
  - A rounding carry that exceeds the range saturates and sets overflow.
- Undefined: pure truncation toward zero; remainder unused.
- Latency is identical in both builds.

Test Plan:
- Exact division:
  - Stimulus: num=−2+14i, den=2+2i.
  - Response: out_valid exactly 27 edges after acceptance; q=3+4i; overflow=0; div_by_zero=0.
- Truncation and rounding, den=2+0i:
  - num=7+0i: q_real=3 (truncating build) or 4 (CPLX_DIV_ROUND_EN).
  - num=−7+0i: q_real=−3 (truncating) or −4 (rounding).
  - q_imag=0 in all four cases.
- Saturation:
  - num=1000+0i, den=1+0i → q=127+0i, overflow=1.
  - num=−1000+0i, den=1+0i → q=−128+0i, overflow=1.
- Zero denominator:
  - Stimulus: den=0+0i, num=5+5i.
  - Response: out_valid 2 edges after acceptance; q=0+0i; div_by_zero=1.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid.
  - Response: outputs stable; in_ready=0; a second in_valid is ignored. Raising out_ready gives one handshake, then in_ready=1 the following cycle.
- Reset mid-operation:
  - Stimulus: assert rst at edge T+10 of a division.
  - Response: next cycle state=IDLE, in_ready=1, out_valid=0, q=0; a fresh operation afterwards completes correctly.
